// File: rtl/imem_arbiter_if.sv
// Bus bundle between the instruction-memory arbiter, its two requesters and the shared BRAM.
// The slave modport is the arbiter's view; master is the view of the surrounding logic.
interface imem_arbiter_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_flush;
  logic              fetch_stall;
  logic              fetch_valid;
  logic [63:0]       fetch_rdata;

  logic              data_req;
  logic              data_we;
  logic [31:0]       data_addr;
  logic [63:0]       data_wdata;
  logic [7:0]        data_wstrb;
  logic              data_gnt;
  logic              data_rvalid;
  logic [63:0]       data_rdata;

  logic              mem_en;
  logic [7:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [63:0]       mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr, fetch_flush,
    input  data_req, data_we, data_addr, data_wdata, data_wstrb,
    input  mem_rdata,
    output fetch_stall, fetch_valid, fetch_rdata,
    output data_gnt, data_rvalid, data_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output fetch_req, fetch_addr, fetch_flush,
    output data_req, data_we, data_addr, data_wdata, data_wstrb,
    output mem_rdata,
    input  fetch_stall, fetch_valid, fetch_rdata,
    input  data_gnt, data_rvalid, data_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Single-port 64-bit BRAM shared between instruction fetch and a data port, one access per cycle,
// with bounded data priority, flush-killed fetch responses and out-of-range read substitution.
module imem_arbiter #(
  parameter int unsigned DEPTH           = 512,
  parameter int unsigned ADDR_W          = 9,
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter logic [63:0] OOR_PATTERN     = 64'hDEADBEEF_DEADBEEF
) (
  input logic            clk,
  input logic            reset,
  imem_arbiter_if.slave  bus
);
  localparam int unsigned StreakW = $clog2(MAX_DATA_STREAK + 1);

  logic [StreakW-1:0] streak;
  logic               respFetch, respData, respOor;
  logic [63:0]        fetchHeld, dataHeld;

  logic               dataWins, fetchGnt, dataGnt, outOfRange;
  logic [28:0]        wordIdx;
  logic [63:0]        respWord;
  logic               fetchValid, dataValid;
  logic               unusedAddrBits;

  assign unusedAddrBits = ^{bus.fetch_addr[2:0], bus.data_addr[2:0]};

  always_comb begin
    // Data has priority until it has won MAX_DATA_STREAK cycles in a row against a waiting fetch.
    dataWins   = bus.data_req & (~bus.fetch_req | (32'(streak) < MAX_DATA_STREAK));
    dataGnt    = ~reset & dataWins;
    fetchGnt   = ~reset & bus.fetch_req & ~dataWins;
    wordIdx    = dataGnt ? bus.data_addr[31:3] : bus.fetch_addr[31:3];
    outOfRange = wordIdx >= 29'(DEPTH);

    bus.mem_en    = (fetchGnt | dataGnt) & ~outOfRange;
    bus.mem_addr  = wordIdx[ADDR_W-1:0];
    bus.mem_wdata = bus.data_wdata;
    bus.mem_we    = (dataGnt & bus.data_we & ~outOfRange) ? bus.data_wstrb : 8'h00;

    bus.fetch_stall = ~reset & bus.fetch_req & ~fetchGnt;
    bus.data_gnt    = dataGnt;

    respWord   = respOor ? OOR_PATTERN : bus.mem_rdata;
    fetchValid = ~reset & respFetch & ~bus.fetch_flush;
    dataValid  = ~reset & respData;

    bus.fetch_valid = fetchValid;
    bus.data_rvalid = dataValid;
    bus.fetch_rdata = reset ? 64'h0 : (fetchValid ? respWord : fetchHeld);
    bus.data_rdata  = reset ? 64'h0 : (dataValid ? respWord : dataHeld);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak    <= '0;
      respFetch <= 1'b0;
      respData  <= 1'b0;
      respOor   <= 1'b0;
      fetchHeld <= 64'h0;
      dataHeld  <= 64'h0;
    end else begin
      respFetch <= fetchGnt;
      respData  <= dataGnt & ~bus.data_we;
      respOor   <= outOfRange;
      if (fetchValid) fetchHeld <= respWord;
      if (dataValid)  dataHeld  <= respWord;
      if (!bus.fetch_req || fetchGnt) begin
        streak <= '0;
      end else if (dataGnt && (32'(streak) < MAX_DATA_STREAK)) begin
        streak <= streak + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: expected responses are queued at grant time with their due
// cycle and compared when the arbiter presents fetch_valid / data_rvalid.
module tb_imem_arbiter;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned ADDR_W = 9;
  localparam logic [63:0] OOR = 64'hDEADBEEF_DEADBEEF;

  typedef struct {
    int          due;
    logic [63:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  resp_t       fetchQ[$];
  resp_t       dataQ[$];
  logic [63:0] refMem [DEPTH];
  logic [63:0] bram [DEPTH];
  logic [63:0] lastFetch = 64'h0;
  logic [63:0] lastData = 64'h0;

  imem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  imem_arbiter #(
    .DEPTH(DEPTH),
    .ADDR_W(ADDR_W),
    .MAX_DATA_STREAK(4),
    .OOR_PATTERN(OOR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port BRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we == 8'h00) begin
        bus.mem_rdata <= bram[bus.mem_addr];
      end else begin
        for (int b = 0; b < 8; b++) begin
          if (bus.mem_we[b]) bram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Response monitor: pops the scoreboard when a response is due, otherwise checks the hold value.
  always @(negedge clk) begin
    logic  expV;
    resp_t e;
    if (reset) begin
      lastFetch = 64'h0;
      lastData  = 64'h0;
    end
    expV = (fetchQ.size() > 0) && (fetchQ[0].due == cyc);
    checkEq("fetch_valid", 64'(bus.fetch_valid), 64'(expV));
    if (expV) begin
      e = fetchQ.pop_front();
      if (bus.fetch_valid) begin
        checkEq("fetch_rdata", bus.fetch_rdata, e.data);
        lastFetch = e.data;
      end
    end else begin
      checkEq("fetch_rdata_hold", bus.fetch_rdata, lastFetch);
    end
    expV = (dataQ.size() > 0) && (dataQ[0].due == cyc);
    checkEq("data_rvalid", 64'(bus.data_rvalid), 64'(expV));
    if (expV) begin
      e = dataQ.pop_front();
      if (bus.data_rvalid) begin
        checkEq("data_rdata", bus.data_rdata, e.data);
        lastData = e.data;
      end
    end else begin
      checkEq("data_rdata_hold", bus.data_rdata, lastData);
    end
  end

  // Drops a response that was queued for the current cycle (flush or reset kills it).
  task automatic dropDue(input logic fetchSide, input logic dataSide);
    if (fetchSide && fetchQ.size() > 0 && fetchQ[fetchQ.size()-1].due == cyc)
      void'(fetchQ.pop_back());
    if (dataSide && dataQ.size() > 0 && dataQ[dataQ.size()-1].due == cyc)
      void'(dataQ.pop_back());
  endtask

  task automatic step(input logic fr, input logic [31:0] fa, input logic fl,
                      input logic dr, input logic dw, input logic [31:0] da,
                      input logic [63:0] wd, input logic [7:0] ws,
                      input logic expF, input logic expD);
    logic [31:0] ga;
    logic        inRange;
    int          idx;
    bus.fetch_req   = fr;
    bus.fetch_addr  = fa;
    bus.fetch_flush = fl;
    bus.data_req    = dr;
    bus.data_we     = dw;
    bus.data_addr   = da;
    bus.data_wdata  = wd;
    bus.data_wstrb  = ws;
    if (fl) dropDue(1'b1, 1'b0);
    @(negedge clk);
    ga      = expD ? da : fa;
    inRange = ga[31:3] < 29'(DEPTH);
    idx     = int'(ga[11:3]);
    checkEq("fetch_stall", 64'(bus.fetch_stall), 64'(fr & ~expF));
    checkEq("data_gnt", 64'(bus.data_gnt), 64'(expD));
    checkEq("mem_en", 64'(bus.mem_en), 64'((expF | expD) & inRange));
    checkEq("mem_we", 64'(bus.mem_we), 64'((expD & dw & inRange) ? ws : 8'h00));
    if ((expF | expD) && inRange) checkEq("mem_addr", 64'(bus.mem_addr), 64'(idx));
    if (expF) fetchQ.push_back('{cyc + 1, inRange ? refMem[idx] : OOR});
    if (expD && !dw) dataQ.push_back('{cyc + 1, inRange ? refMem[idx] : OOR});
    if (expD && dw && inRange) begin
      for (int b = 0; b < 8; b++) if (ws[b]) refMem[idx][8*b +: 8] = wd[8*b +: 8];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic fetch(input logic [31:0] a);
    step(1'b1, a, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic dwrite(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, a, d, s, 1'b0, 1'b1);
  endtask

  task automatic resetCycle();
    reset = 1'b1;
    bus.fetch_req = 1'b1;
    bus.data_req  = 1'b1;
    bus.data_we   = 1'b1;
    bus.data_wstrb = 8'hFF;
    dropDue(1'b1, 1'b1);
    @(negedge clk);
    checkEq("rst_fetch_stall", 64'(bus.fetch_stall), 64'h0);
    checkEq("rst_data_gnt", 64'(bus.data_gnt), 64'h0);
    checkEq("rst_mem_en", 64'(bus.mem_en), 64'h0);
    checkEq("rst_mem_we", 64'(bus.mem_we), 64'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) refMem[i] = 64'h0;
    reset           = 1'b1;
    bus.fetch_flush = 1'b0;
    bus.fetch_addr  = 32'h0;
    bus.data_addr   = 32'h0;
    bus.data_wdata  = 64'h0;
    resetCycle();
    resetCycle();
    reset = 1'b0;

    dwrite(32'h00, 64'h11111111_00000000, 8'hFF);
    dwrite(32'h08, 64'h33333333_22222222, 8'hFF);
    dwrite(32'h10, 64'h55555555_44444444, 8'hFF);
    idle();

    // Fetch-only, back to back
    fetch(32'h0);
    fetch(32'h8);
    idle();
    idle();

    // Contention: D,D,D,D,F repeating
    for (int i = 0; i < 10; i++)
      step(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h8, 64'h0, 8'h00, (i % 5) == 4, (i % 5) != 4);
    idle();
    idle();

    // Partial write then read back
    dwrite(32'h10, 64'hAABBCCDD_EEFF0011, 8'h0F);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h10, 64'h0, 8'h00, 1'b0, 1'b1);
    idle();
    idle();

    // Flush kills the 0x18 response, the same-cycle 0x14 fetch survives
    fetch(32'h18);
    step(1'b1, 32'h14, 1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 8'h00, 1'b1, 1'b0);
    idle();
    idle();

    // Out-of-range fetch and write; word 0 must be untouched
    fetch(32'h1000);
    dwrite(32'h1000, 64'hFFFFFFFF_FFFFFFFF, 8'hFF);
    idle();
    fetch(32'h0);
    idle();

    // Reset right after a fetch grant
    fetch(32'h8);
    resetCycle();
    reset = 1'b0;
    fetch(32'h0);
    fetch(32'h8);
    idle();
    idle();

    checkEq("fetch_queue_drained", 64'(fetchQ.size()), 64'h0);
    checkEq("data_queue_drained", 64'(dataQ.size()), 64'h0);
    checkEq("word2_final", refMem[2], 64'h55555555_EEFF0011);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
